// File: rtl/alu_8bit.sv
// alu_8bit: one-cycle registered 8-bit ALU; define ALU_8BIT_DIV_EN to build the divider
module alu_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [2:0]  sel,
    input  logic        in_valid,
    output logic [15:0] res,
    output logic        out_valid,
    output logic        zero,
    output logic        dbz
);
    logic [15:0] ax, bx, r;
    logic        d;
    assign ax = {8'h00, a};
    assign bx = {8'h00, b};
    // next result and divide-by-zero flag for the current opcode
    always_comb begin
        d = 1'b0;
        r = 16'h0000;
        case (sel)
            3'b000: r = ax + bx;
            3'b001: r = ax - bx;
            3'b010: r = ax * bx;
`ifdef ALU_8BIT_DIV_EN
            3'b011: begin
                d = (b == 8'h00);
                r = d ? 16'h00FF : {a % b, a / b};
            end
`else
            3'b011: r = 16'h0000;
`endif
            3'b100: r = ax & bx;
            3'b101: r = ax | bx;
            3'b110: r = 16'h0000 - ax;
            default: r = ax ^ bx;
        endcase
    end
    // capture on accepted input, otherwise hold result/flags and drop the valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= 16'h0000;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res  <= r;
                zero <= (r == 16'h0000);
                dbz  <= d;
            end
        end
    end
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and random checks of alu_8bit against an arithmetic reference model
module tb_alu_8bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a = 8'h00, b = 8'h00;
    logic [2:0]  sel = 3'b000;
    logic        in_valid = 1'b0;
    logic [15:0] res;
    logic        out_valid, zero, dbz;
    int          tests = 0, fails = 0;
    logic [15:0] last_res = 16'h0000;
    logic        last_zero = 1'b0, last_dbz = 1'b0;

    alu_8bit dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .in_valid(in_valid),
        .res(res), .out_valid(out_valid), .zero(zero), .dbz(dbz)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] ms);
        int x, y, v, z;
        x = ma;
        y = mb;
        z = 0;
        case (ms)
            3'd0: v = x + y;
            3'd1: v = x - y;
            3'd2: v = x * y;
`ifdef ALU_8BIT_DIV_EN
            3'd3: begin
                if (y == 0) begin
                    v = 255;
                    z = 1;
                end else v = (x % y) * 256 + x / y;
            end
`else
            3'd3: v = 0;
`endif
            3'd4: v = x & y;
            3'd5: v = x | y;
            3'd6: v = -x;
            default: v = x ^ y;
        endcase
        return {z[0], 16'(v & 32'hFFFF)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts, input string tag);
        logic [16:0] m;
        @(negedge clk);
        a = ta;
        b = tb;
        sel = ts;
        in_valid = 1'b1;
        m = model(ta, tb, ts);
        @(posedge clk);
        #1;
        chk({tag, "_res"}, res, m[15:0]);
        chk({tag, "_vld"}, 16'(out_valid), 16'd1);
        chk({tag, "_zero"}, 16'(zero), 16'(m[15:0] == 16'h0000));
        chk({tag, "_dbz"}, 16'(dbz), 16'(m[16]));
        last_res = m[15:0];
        last_zero = (m[15:0] == 16'h0000);
        last_dbz = m[16];
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sel = 3'($urandom);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 16'(out_valid), 16'd0);
        chk({tag, "_hold_res"}, res, last_res);
        chk({tag, "_hold_zero"}, 16'(zero), 16'(last_zero));
        chk({tag, "_hold_dbz"}, 16'(dbz), 16'(last_dbz));
    endtask

    initial begin
        #2;
        chk("rst_res", res, 16'h0000);
        chk("rst_vld", 16'(out_valid), 16'd0);
        chk("rst_zero", 16'(zero), 16'd0);
        chk("rst_dbz", 16'(dbz), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(8'd2, 8'd3, 3'd0, "add");    chk("add_lit", res, 16'h0005);
        op(8'd3, 8'd2, 3'd1, "sub");    chk("sub_lit", res, 16'h0001);
        op(8'd2, 8'd3, 3'd1, "subw");   chk("subw_lit", res, 16'hFFFF);
        op(8'd255, 8'd1, 3'd0, "addc"); chk("addc_lit", res, 16'h0100);
        op(8'd2, 8'd3, 3'd2, "mul");    chk("mul_lit", res, 16'h0006);
        op(8'd255, 8'd255, 3'd2, "mulx"); chk("mulx_lit", res, 16'hFE01);
`ifdef ALU_8BIT_DIV_EN
        op(8'd2, 8'd3, 3'd3, "div");    chk("div_lit", res, 16'h0200);
        chk("div_dbz", 16'(dbz), 16'd0);
        op(8'd3, 8'd0, 3'd3, "div0");   chk("div0_lit", res, 16'h00FF);
        chk("div0_dbz", 16'(dbz), 16'd1);
`else
        op(8'd2, 8'd3, 3'd3, "nodiv");  chk("nodiv_lit", res, 16'h0000);
        chk("nodiv_zero", 16'(zero), 16'd1);
`endif
        op(8'd2, 8'd3, 3'd4, "and");    chk("and_lit", res, 16'h0002);
        op(8'd2, 8'd3, 3'd5, "or");     chk("or_lit", res, 16'h0003);
        op(8'd2, 8'd3, 3'd7, "xor");    chk("xor_lit", res, 16'h0001);
        op(8'd2, 8'd3, 3'd6, "neg");    chk("neg_lit", res, 16'hFFFE);
        op(8'd5, 8'd5, 3'd1, "subz");   chk("subz_lit", res, 16'h0000);
        chk("subz_zero", 16'(zero), 16'd1);
        idle("idle_z");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle("rnd_idle");
            else op(8'($urandom), ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom), 3'($urandom), "rnd");
        end

        op(8'd200, 8'd100, 3'd2, "pre_rst");
        @(negedge clk);
        a = 8'd9;
        b = 8'd4;
        sel = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_res", res, 16'h0000);
        chk("midrst_vld", 16'(out_valid), 16'd0);
        chk("midrst_dbz", 16'(dbz), 16'd0);
        chk("midrst_zero", 16'(zero), 16'd0);
        @(posedge clk);
        #1;
        chk("inrst_res", res, 16'h0000);
        chk("inrst_vld", 16'(out_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_res", res, 16'h000D);
        chk("first_vld", 16'(out_valid), 16'd1);
        last_res = 16'h000D;
        last_zero = 1'b0;
        last_dbz = 1'b0;
        idle("post_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port a, input, 8 bits, unsigned operand A.
REQ-005 The block SHALL have port b, input, 8 bits, unsigned operand B.
REQ-006 The block SHALL have port sel, input, 3 bits, opcode.
REQ-007 The block SHALL have port in_valid, input, 1 bit, operands/opcode valid this cycle.
REQ-008 The block SHALL have port res, output, 16 bits, registered result.
REQ-009 The block SHALL have port out_valid, output, 1 bit, res valid pulse.
REQ-010 The block SHALL have port zero, output, 1 bit, set when res == 16'h0000 with out_valid.
REQ-011 The block SHALL have port dbz, output, 1 bit, divide-by-zero flag.

Function
REQ-012 The opcode encoding SHALL be:
- 000 ADD
- 001 SUB
- 010 MUL
- 011 DIV
- 100 AND
- 101 OR
- 110 NEG
- 111 XOR

REQ-013 ADD SHALL give res = zero-extended a + b; the carry lands in res[8], e.g. 255 + 1 = 16'h0100.
REQ-014 SUB SHALL give res = a - b computed in 16 bits with two's-complement wrap, e.g. 2 - 3 = 16'hFFFF.
REQ-015 MUL SHALL give res = full 16-bit unsigned product a * b.
REQ-016 DIV with b != 0 SHALL give res[7:0] = a / b (unsigned quotient), res[15:8] = a % b, and dbz = 0.
REQ-017 DIV with b == 0 SHALL give res = 16'h00FF and dbz = 1.
REQ-018 AND, OR and XOR SHALL each give res = {8'h00, a op b}.
REQ-019 NEG SHALL give res = 16-bit two's complement of zero-extended a, e.g. a = 2 gives 16'hFFFE; b is ignored.
REQ-020 dbz SHALL be 0 for every non-DIV opcode.
REQ-021 Latency SHALL be exactly one cycle: a, b and sel sampled on the clk rising edge where in_valid = 1 produce res, zero, dbz and out_valid = 1 after that same edge.
REQ-022 out_valid SHALL be a one-cycle pulse per accepted input and is asserted on back-to-back cycles for back-to-back inputs.
REQ-023 When in_valid = 0, res, zero and dbz SHALL hold their previous values and out_valid SHALL be 0.
REQ-024 There SHALL be no backpressure; every in_valid = 1 cycle is accepted.

Reset
REQ-025 While rst_n = 0, res SHALL be 16'h0000 and out_valid, zero and dbz SHALL be 0, immediately and independently of clk.
REQ-026 An operation in flight when rst_n asserts SHALL be discarded.
REQ-027 The first operation SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 The block SHALL use macro ALU_8BIT_DIV_EN to compile the divider in or out.
REQ-029 With ALU_8BIT_DIV_EN defined, DIV SHALL behave per REQ-016 and REQ-017.
REQ-030 Without ALU_8BIT_DIV_EN defined, no divider logic SHALL be built, DIV SHALL give res = 16'h0000 with zero = 1, and dbz SHALL be constant 0.

Verification
REQ-031 With rst_n = 0 mid-stream, the bench SHALL check that res = 0, out_valid = 0 and dbz = 0 immediately, before any clk edge.
REQ-032 The bench SHALL check a = 2, b = 3, ADD -> res = 16'h0005; a = 3, b = 2, SUB -> res = 16'h0001; a = 2, b = 3, SUB -> res = 16'hFFFF; each one cycle later with out_valid = 1.
REQ-033 The bench SHALL check a = 2, b = 3, MUL -> 16'h0006; a = 255, b = 255, MUL -> 16'hFE01.
REQ-034 With ALU_8BIT_DIV_EN defined, the bench SHALL check a = 2, b = 3, DIV -> res = 16'h0200 and dbz = 0; a = 3, b = 0, DIV -> res = 16'h00FF and dbz = 1.
REQ-035 The bench SHALL check a = 2, b = 3 for AND -> 16'h0002, OR -> 16'h0003, XOR -> 16'h0001 and NEG -> 16'hFFFE.
REQ-036 The bench SHALL check that a = 5, b = 5, SUB gives res = 0 and zero = 1, and that a following in_valid = 0 cycle holds res with out_valid = 0.
